// File: rtl/freq_counter_if.sv
// freq_counter_if
//   Display-side bus of the frequency counter: the two BCD digits and the
//   one-cycle load strobe that tells the seven-segment driver to take them.
//
//   Signals
//     ten_count   [3:0]  BCD tens digit, held between loads
//     unit_count  [3:0]  BCD units digit, held between loads
//     load               one-cycle strobe, digits valid while high
//
//   Modports
//     master  driven by freq_counter
//     slave   consumed by the display driver
interface freq_counter_if;
  logic [3:0] ten_count;
  logic [3:0] unit_count;
  logic       load;

  modport master (
    output ten_count,
    output unit_count,
    output load
  );

  modport slave (
    input ten_count,
    input unit_count,
    input load
  );
endinterface

// File: rtl/freq_counter.sv
// freq_counter
//   Measurement front end of the frequency counter. The asynchronous input
//   `signal` is synchronised and its rising edges are counted over a gate
//   window of UPDATE_PERIOD clock cycles. At the end of each window the count
//   is converted to two BCD digits by repeated subtraction of ten, and the
//   digits are handed to the display driver with a one-cycle load strobe.
//
//   Parameters
//     UPDATE_PERIOD  gate window length in clk cycles (>= 2)
//
//   Ports
//     clk     system clock, rising edge
//     reset   asynchronous active-high reset, clears all state
//     signal  asynchronous input whose frequency is measured
//     disp    freq_counter_if.master: ten_count, unit_count, load
//
//   Build option
//     FREQ_OVERRANGE_BLANK_EN  when defined, a count >= 100 loads 4'hF into
//                              both digits (shown blank by the decoder);
//                              otherwise the display clamps to 9/9.
module freq_counter #(
  parameter int unsigned UPDATE_PERIOD = 1200
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           signal,
  freq_counter_if.master disp
);

  localparam int unsigned   GW        = $clog2(UPDATE_PERIOD);
  localparam logic [GW-1:0] GATE_LAST = GW'(UPDATE_PERIOD - 1);
  localparam logic [6:0]    EDGE_MAX  = 7'd127;
  localparam logic [6:0]    OVR_LIMIT = 7'd100;
  localparam logic [6:0]    TEN       = 7'd10;

`ifdef FREQ_OVERRANGE_BLANK_EN
  localparam logic [3:0] OVR_DIGIT = 4'hF;
`else
  localparam logic [3:0] OVR_DIGIT = 4'd9;
`endif

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    TENS  = 2'd1,
    UNITS = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Input synchroniser and edge history
  logic sig_s1;
  logic sig_s2;
  logic sig_d;
  logic edge_det;

  // Measurement datapath
  logic [GW-1:0] gate_cnt;
  logic [6:0]    edge_cnt;
  logic [3:0]    tens_reg;
  logic          overrange;

  // Decoded conditions
  logic gate_done;
  logic over_hit;
  logic tens_step;

  always_comb begin
    edge_det  = sig_s2 & ~sig_d;
    gate_done = (gate_cnt == GATE_LAST);
    over_hit  = (edge_cnt >= OVR_LIMIT);
    tens_step = (edge_cnt >= TEN) && !over_hit;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      COUNT: begin
        if (gate_done) begin
          state_nxt = TENS;
        end
      end
      TENS: begin
        // Stay here while a ten can still be taken off the count; an
        // overrange count skips the conversion entirely.
        if (!tens_step) begin
          state_nxt = UNITS;
        end
      end
      UNITS: begin
        state_nxt = COUNT;
      end
      default: begin
        state_nxt = COUNT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Synchroniser
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_s1 <= 1'b0;
      sig_s2 <= 1'b0;
      sig_d  <= 1'b0;
    end else begin
      sig_s1 <= signal;
      sig_s2 <= sig_s1;
      sig_d  <= sig_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // Gate counter, edge counter and BCD conversion
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      tens_reg  <= '0;
      overrange <= 1'b0;
    end else begin
      case (state)
        COUNT: begin
          gate_cnt <= gate_done ? '0 : gate_cnt + 1'b1;
          // Saturate rather than wrap so a fast input still reads overrange.
          if (edge_det && (edge_cnt != EDGE_MAX)) begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end
        TENS: begin
          if (over_hit) begin
            overrange <= 1'b1;
          end else if (tens_step) begin
            edge_cnt <= edge_cnt - TEN;
            tens_reg <= tens_reg + 1'b1;
          end
        end
        UNITS: begin
          edge_cnt  <= '0;
          tens_reg  <= '0;
          overrange <= 1'b0;
        end
        default: begin
          gate_cnt <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display outputs: registered, updated only on the UNITS edge
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp.ten_count  <= '0;
      disp.unit_count <= '0;
      disp.load       <= 1'b0;
    end else begin
      disp.load <= (state == UNITS);
      if (state == UNITS) begin
        if (overrange) begin
          disp.ten_count  <= OVR_DIGIT;
          disp.unit_count <= OVR_DIGIT;
        end else begin
          // After the TENS loop the remainder is below ten and fits 4 bits.
          disp.ten_count  <= tens_reg;
          disp.unit_count <= edge_cnt[3:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// tb_freq_counter
//   Directed bench for freq_counter. dut_a uses a 100-cycle gate window,
//   dut_b a 400-cycle window so that counts of 100 and above are reachable.
//   Window cycle k = 1 is the first rising edge after reset release or after
//   the negedge at which load was seen; the signal value sampled at edge k is
//   driven on the preceding negedge. A rise sampled at edge k is counted when
//   k <= P-2, and load is then seen after edge P+2+tens.
module tb_freq_counter;

  logic clk;
  logic reset;
  logic sig_a;
  logic sig_b;

  int checks;
  int errors;

`ifdef FREQ_OVERRANGE_BLANK_EN
  localparam logic [3:0] OVR = 4'hF;
`else
  localparam logic [3:0] OVR = 4'd9;
`endif

  freq_counter_if if_a ();
  freq_counter_if if_b ();

  freq_counter #(.UPDATE_PERIOD(100)) dut_a (
    .clk    (clk),
    .reset  (reset),
    .signal (sig_a),
    .disp   (if_a)
  );

  freq_counter #(.UPDATE_PERIOD(400)) dut_b (
    .clk    (clk),
    .reset  (reset),
    .signal (sig_b),
    .disp   (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Signal value sampled at window edge k: n pulses of period 2 starting at s,
  // an optional single injected pulse at inj, or a toggle on every odd edge
  // up to the window end.
  function automatic logic sched(input int k, input int s, input int n,
                                 input int inj, input bit tog, input int p);
    if (tog) return (k <= p) && (k % 2 == 1);
    if (n > 0 && k >= s && k <= s + 2 * (n - 1) && ((k - s) % 2 == 0)) return 1'b1;
    if (inj > 0 && k == inj) return 1'b1;
    return 1'b0;
  endfunction

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_window(input bit sel, input string name, input int p,
                            input int n, input int s, input int inj, input bit tog,
                            input logic [3:0] exp_t, input logic [3:0] exp_u,
                            input int exp_k,
                            input logic [3:0] prev_t, input logic [3:0] prev_u);
    int k;
    bit seen;
    logic v;
    logic ld;
    logic [3:0] tc;
    logic [3:0] uc;
    k = 0;
    seen = 1'b0;
    tc = '0;
    uc = '0;
    while (!seen && k < p + 30) begin
      k++;
      v = sched(k, s, n, inj, tog, p);
      if (sel) sig_b = v; else sig_a = v;
      @(posedge clk);
      @(negedge clk);
      ld = sel ? if_b.load : if_a.load;
      tc = sel ? if_b.ten_count : if_a.ten_count;
      uc = sel ? if_b.unit_count : if_a.unit_count;
      if (k == 1) begin
        checks++;
        if (ld !== 1'b0) begin
          errors++;
          $display("FAIL %s_load_width: load=%b at window cycle 1, required 0", name, ld);
        end
      end
      if (k == p / 2) begin
        checks++;
        if (tc !== prev_t || uc !== prev_u) begin
          errors++;
          $display("FAIL %s_hold: digits %h/%h mid-window, required %h/%h",
                   name, tc, uc, prev_t, prev_u);
        end
      end
      if (k > 1 && ld === 1'b1) seen = 1'b1;
    end
    sig_a = sel ? sig_a : 1'b0;
    sig_b = sel ? 1'b0 : sig_b;
    checks++;
    if (!seen || k != exp_k) begin
      errors++;
      $display("FAIL %s_load_time: load seen=%0d at cycle %0d, required at cycle %0d",
               name, seen, k, exp_k);
    end
    checks++;
    if (tc !== exp_t || uc !== exp_u) begin
      errors++;
      $display("FAIL %s_digits: got %h/%h, required %h/%h", name, tc, uc, exp_t, exp_u);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (if_a.ten_count !== 4'd0 || if_a.unit_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_digits_a: got %h/%h, required 0/0", if_a.ten_count, if_a.unit_count);
    end
    checks++;
    if (if_a.load !== 1'b0) begin
      errors++;
      $display("FAIL reset_load_a: got %b, required 0", if_a.load);
    end
    checks++;
    if (if_b.ten_count !== 4'd0 || if_b.unit_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_digits_b: got %h/%h, required 0/0", if_b.ten_count, if_b.unit_count);
    end
    checks++;
    if (if_b.load !== 1'b0) begin
      errors++;
      $display("FAIL reset_load_b: got %b, required 0", if_b.load);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_window(1'b0, "edges42", 100, 42, 2, 0, 1'b0, 4'd4, 4'd2, 106, 4'd0, 4'd0);
  endtask

  task automatic test_reset_mid_window();
    int loads;
    loads = 0;
    for (int k = 1; k <= 50; k++) begin
      sig_a = sched(k, 2, 30, 0, 1'b0, 100);
      @(posedge clk);
      @(negedge clk);
      if (if_a.load === 1'b1) loads++;
    end
    checks++;
    if (loads != 0) begin
      errors++;
      $display("FAIL midreset_early_load: %0d loads before reset, required 0", loads);
    end
    reset = 1'b1;
    sig_a = 1'b0;
    #1;
    checks++;
    if (if_a.ten_count !== 4'd0 || if_a.unit_count !== 4'd0 || if_a.load !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: got %h/%h load=%b, required 0/0 load=0",
               if_a.ten_count, if_a.unit_count, if_a.load);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_window(1'b0, "midreset_next", 100, 0, 2, 0, 1'b0, 4'd0, 4'd0, 102, 4'd0, 4'd0);
  endtask

  task automatic test_discard();
    run_window(1'b0, "discard_tens", 100, 7, 2, 99, 1'b0, 4'd0, 4'd7, 102, 4'd0, 4'd0);
    run_window(1'b0, "discard_units", 100, 5, 2, 100, 1'b0, 4'd0, 4'd5, 102, 4'd0, 4'd7);
    run_window(1'b0, "discard_after", 100, 2, 2, 0, 1'b0, 4'd0, 4'd2, 102, 4'd0, 4'd5);
  endtask

  task automatic test_back_to_back();
    run_window(1'b0, "b2b_15", 100, 15, 2, 0, 1'b0, 4'd1, 4'd5, 103, 4'd0, 4'd2);
    run_window(1'b0, "b2b_3", 100, 3, 2, 0, 1'b0, 4'd0, 4'd3, 102, 4'd1, 4'd5);
  endtask

  task automatic test_boundary();
    pulse_reset();
    run_window(1'b1, "edges99", 400, 99, 2, 0, 1'b0, 4'd9, 4'd9, 411, 4'd0, 4'd0);
    run_window(1'b1, "edges100", 400, 100, 2, 0, 1'b0, OVR, OVR, 402, 4'd9, 4'd9);
  endtask

  task automatic test_saturation();
    run_window(1'b1, "saturate", 400, 0, 0, 0, 1'b1, OVR, OVR, 402, OVR, OVR);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_reset_mid_window();
    test_discard();
    test_back_to_back();
    test_boundary();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
